// File: rtl/uart_tx_buf.sv
// uart_tx_buf -- buffered 8N1 UART transmitter.
//
// Byte strobes from the row-sum controller are queued in a DEPTH-entry FIFO
// and serialised LSB-first on tx at CLK_FREQ/BAUD clocks per bit. A frame is
// one start bit (0), eight data bits and one stop bit (1). When the FIFO
// holds another byte at the end of a stop bit, the next start bit follows
// with no idle gap.
//
// Ports:
//   sys_clk   in   1  system clock, rising edge
//   rst_n     in   1  asynchronous active-low reset
//   tx_data   in   8  byte to queue, sampled when tx_en=1
//   tx_en     in   1  write strobe, one byte per high cycle
//   tx        out  1  serial line, idle high (registered)
//   busy      out  1  FIFO non-empty or frame in progress (registered)
//   overflow  out  1  one-cycle pulse after a byte is dropped on a full FIFO
module uart_tx_buf #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600,
    parameter int DEPTH    = 8
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_en,
    output logic       tx,
    output logic       busy,
    output logic       overflow
);

    localparam int BIT_CYC = CLK_FREQ / BAUD;
    localparam int CNT_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO  = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_EMPTY = (PTR_W + 1)'(0);
    localparam logic [PTR_W:0]   COUNT_ONE = (PTR_W + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic [7:0]       mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             overflow_r;

    state_t           state_r;
    state_t           state_s;
    logic [7:0]       shift_r;
    logic [7:0]       shift_s;
    logic [2:0]       bit_idx_r;
    logic [2:0]       bit_idx_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             tx_r;
    logic             tx_s;
    logic             busy_r;

    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic             bit_done_s;

    // FIFO status and push qualification; full is judged before any same-cycle pop
    always_comb begin
        full_s  = (count_r == CNT_FULL);
        empty_s = (count_r == CNT_EMPTY);
        push_s  = tx_en & ~full_s;
    end

    // FIFO storage write; contents need no reset because count gates every read
    always_ff @(posedge sys_clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= tx_data;
        end
    end

    // FIFO pointers, occupancy and overflow pulse
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_EMPTY;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + COUNT_ONE;
                2'b01:   count_r <= count_r - COUNT_ONE;
                default: count_r <= count_r;
            endcase
            overflow_r <= tx_en & full_s;
        end
    end

    // Frame sequencer next-state: baud count, bit index, shifter and FIFO pop
    always_comb begin
        state_s    = state_r;
        shift_s    = shift_r;
        bit_idx_s  = bit_idx_r;
        cnt_s      = cnt_r;
        pop_s      = 1'b0;
        bit_done_s = (cnt_r == CNT_LAST);
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    shift_s = mem_r[rd_ptr_r];
                    state_s = ST_START;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s   = CNT_ZERO;
                end
            end
            ST_START: begin
                if (bit_done_s) begin
                    state_s   = ST_DATA;
                    bit_idx_s = 3'd0;
                    cnt_s     = CNT_ZERO;
                end else begin
                    cnt_s     = cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (bit_done_s) begin
                    shift_s   = {1'b0, shift_r[7:1]};
                    bit_idx_s = bit_idx_r + 3'd1;
                    cnt_s     = CNT_ZERO;
                    if (bit_idx_r == 3'd7) begin
                        state_s = ST_STOP;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    cnt_s     = cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (bit_done_s) begin
                    cnt_s = CNT_ZERO;
                    // A queued byte chains straight into the next start bit
                    if (!empty_s) begin
                        pop_s   = 1'b1;
                        shift_s = mem_r[rd_ptr_r];
                        state_s = ST_START;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Line level decoded from the current state; registered one clock later
    always_comb begin
        case (state_r)
            ST_START: tx_s = 1'b0;
            ST_DATA:  tx_s = shift_r[0];
            default:  tx_s = 1'b1;
        endcase
    end

    // Sequencer state register and registered tx/busy outputs
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            shift_r   <= 8'h00;
            bit_idx_r <= 3'd0;
            cnt_r     <= CNT_ZERO;
            tx_r      <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            shift_r   <= shift_s;
            bit_idx_r <= bit_idx_s;
            cnt_r     <= cnt_s;
            tx_r      <= tx_s;
            busy_r    <= (state_r != ST_IDLE) | ~empty_s;
        end
    end

    assign tx       = tx_r;
    assign busy     = busy_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Testbench for uart_tx_buf (CLK_FREQ=1000, BAUD=100 -> 10 clocks/bit, DEPTH=8).
// A reference model predicts each frame's start cycle from the queueing rules
// (start = max(accept edge + 2, previous start + 100); a byte is dropped when
// DEPTH accepted bytes have not yet started), and from that derives the
// expected tx, busy and overflow on every cycle. A line monitor decodes frames.
module tb_uart_tx_buf;

    localparam int DEPTH = 8;
    localparam int FRAME = 100;

    logic       sys_clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       tx;
    logic       busy;
    logic       overflow;

    int n_checks;
    int n_pass;
    int cyc;

    // reference model: accepted bytes, their accept edges, predicted start cycles
    logic [7:0] m_byte [$];
    int         m_acc [$];
    int         m_start [$];
    int         m_ovf [$];

    // line monitor output
    logic [7:0] rx_q [$];
    int         rx_start_q [$];
    logic       rx_stop_q [$];

    int err_tx, err_busy, err_ovf;
    int first_tx, first_busy, first_ovf;
    int ovf_cnt, ovf_cyc;

    uart_tx_buf #(
        .CLK_FREQ(1000),
        .BAUD    (100),
        .DEPTH   (DEPTH)
    ) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .tx_data (tx_data),
        .tx_en   (tx_en),
        .tx      (tx),
        .busy    (busy),
        .overflow(overflow)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // cycle index: value equals the number of the most recent rising edge
    initial begin
        cyc = 0;
        forever begin
            @(posedge sys_clk);
            cyc = cyc + 1;
        end
    end

    // line monitor: mid-bit sampling of each frame, aborts on reset
    initial begin
        logic       in_frame;
        int         pos;
        int         fstart;
        logic [7:0] sh;
        logic       stp;
        in_frame = 1'b0;
        pos = 0;
        fstart = 0;
        sh = 8'h00;
        stp = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (rst_n !== 1'b1) begin
                in_frame = 1'b0;
            end else if (!in_frame) begin
                if (tx === 1'b0) begin
                    in_frame = 1'b1;
                    pos = 0;
                    fstart = cyc;
                    sh = 8'h00;
                end
            end else begin
                pos = pos + 1;
                if (pos >= 15 && pos <= 85 && (pos % 10) == 5) sh[(pos - 15) / 10] = tx;
                if (pos == 95) stp = tx;
                if (pos == 99) begin
                    in_frame = 1'b0;
                    rx_q.push_back(sh);
                    rx_start_q.push_back(fstart);
                    rx_stop_q.push_back(stp);
                end
            end
        end
    end

    function automatic logic exp_tx(input int t);
        for (int i = m_start.size() - 1; i >= 0; i--) begin
            int p;
            p = t - m_start[i];
            if (p >= 0 && p < FRAME) begin
                if (p < 10) return 1'b0;
                if (p >= 90) return 1'b1;
                return m_byte[i][(p - 10) / 10];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic exp_busy(input int t);
        for (int i = 0; i < m_acc.size(); i++) begin
            if (t >= m_acc[i] + 1 && t <= m_start[i] + FRAME - 1) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic exp_ovf(input int t);
        for (int i = 0; i < m_ovf.size(); i++) begin
            if (m_ovf[i] == t) return 1'b1;
        end
        return 1'b0;
    endfunction

    // model a strobe sampled at rising edge e
    function automatic void model_push(input logic [7:0] d, input int e);
        int pending;
        int s;
        pending = 0;
        for (int i = 0; i < m_start.size(); i++) begin
            if (m_start[i] > e) pending++;
        end
        if (pending >= DEPTH) begin
            m_ovf.push_back(e);
        end else begin
            s = e + 2;
            if (m_start.size() > 0 && m_start[m_start.size() - 1] + FRAME > s)
                s = m_start[m_start.size() - 1] + FRAME;
            m_byte.push_back(d);
            m_acc.push_back(e);
            m_start.push_back(s);
        end
    endfunction

    task automatic reset_model();
        m_byte.delete();
        m_acc.delete();
        m_start.delete();
        m_ovf.delete();
        rx_q.delete();
        rx_start_q.delete();
        rx_stop_q.delete();
        err_tx = 0; err_busy = 0; err_ovf = 0;
        first_tx = -1; first_busy = -1; first_ovf = -1;
        ovf_cnt = 0; ovf_cyc = -1;
    endtask

    // drive one clock from a falling edge, then score outputs against the model
    task automatic advance(input logic en, input logic [7:0] d);
        tx_en = en;
        tx_data = d;
        if (en) model_push(d, cyc + 1);
        @(negedge sys_clk);
        tx_en = 1'b0;
        if (tx !== exp_tx(cyc)) begin
            if (err_tx == 0) first_tx = cyc;
            err_tx++;
        end
        if (busy !== exp_busy(cyc)) begin
            if (err_busy == 0) first_busy = cyc;
            err_busy++;
        end
        if (overflow !== exp_ovf(cyc)) begin
            if (err_ovf == 0) first_ovf = cyc;
            err_ovf++;
        end
        if (overflow === 1'b1) begin
            ovf_cnt++;
            ovf_cyc = cyc;
        end
    endtask

    task automatic test_reset();
        reset_model();
        rst_n = 1'b0;
        tx_en = 1'b0;
        tx_data = 8'h00;
        repeat (5) @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);
        n_checks++;
        if ({tx, busy, overflow} !== 3'b100) $display("FAIL reset_outputs: tx/busy/ovf got %b required 100", {tx, busy, overflow});
        else n_pass++;
        repeat (50) advance(1'b0, 8'h00);
        n_checks++;
        if (err_tx !== 0) $display("FAIL reset_idle_tx: %0d bad cycles (first %0d) required 0", err_tx, first_tx);
        else n_pass++;
        n_checks++;
        if (err_busy !== 0) $display("FAIL reset_idle_busy: %0d bad cycles (first %0d) required 0", err_busy, first_busy);
        else n_pass++;
    endtask

    task automatic test_single();
        int n;
        int busy_fall;
        reset_model();
        n = cyc + 1;
        busy_fall = -1;
        advance(1'b1, 8'hA5);
        repeat (110) begin
            advance(1'b0, 8'h00);
            if (busy === 1'b0 && busy_fall < 0 && cyc > n + 1) busy_fall = cyc;
        end
        n_checks++;
        if (err_tx !== 0) $display("FAIL single_wave: %0d bad tx cycles (first %0d) required 0", err_tx, first_tx);
        else n_pass++;
        n_checks++;
        if (busy_fall !== n + 102) $display("FAIL single_busy_fall: got edge N+%0d required N+102", busy_fall - n);
        else n_pass++;
        n_checks++;
        if (rx_q.size() !== 1) $display("FAIL single_count: got %0d frames required 1", rx_q.size());
        else n_pass++;
        if (rx_q.size() == 1) begin
            n_checks++;
            if (rx_q[0] !== 8'hA5 || rx_stop_q[0] !== 1'b1) $display("FAIL single_byte: got %h stop %b required a5 stop 1", rx_q[0], rx_stop_q[0]);
            else n_pass++;
            n_checks++;
            if (rx_start_q[0] !== n + 2) $display("FAIL single_latency: start at N+%0d required N+2", rx_start_q[0] - n);
            else n_pass++;
        end
    endtask

    task automatic test_burst();
        int n;
        int bad;
        reset_model();
        n = cyc + 1;
        for (int i = 0; i < 10; i++) advance(1'b1, 8'(i));
        repeat (940) advance(1'b0, 8'h00);
        n_checks++;
        if (err_tx !== 0 || err_busy !== 0 || err_ovf !== 0)
            $display("FAIL burst_model: tx/busy/ovf bad cycles got %0d/%0d/%0d required 0/0/0", err_tx, err_busy, err_ovf);
        else n_pass++;
        n_checks++;
        if (ovf_cnt !== 1 || ovf_cyc !== n + 9) $display("FAIL burst_overflow: got %0d pulses at N+%0d required 1 at N+9", ovf_cnt, ovf_cyc - n);
        else n_pass++;
        n_checks++;
        if (rx_q.size() !== 9) $display("FAIL burst_count: got %0d frames required 9", rx_q.size());
        else n_pass++;
        bad = 0;
        for (int i = 0; i < rx_q.size() && i < 9; i++) begin
            if (rx_q[i] !== 8'(i) || rx_stop_q[i] !== 1'b1) bad++;
            if (rx_start_q[i] !== n + 2 + FRAME * i) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL burst_frames: %0d wrong bytes/starts required 0", bad);
        else n_pass++;
    endtask

    task automatic test_write_during();
        int n;
        reset_model();
        n = cyc + 1;
        advance(1'b1, 8'h3C);
        while (cyc < n + 55) advance(1'b0, 8'h00);
        advance(1'b1, 8'hC3);
        repeat (230) advance(1'b0, 8'h00);
        n_checks++;
        if (err_tx !== 0 || ovf_cnt !== 0) $display("FAIL during_wave: bad tx cycles %0d overflow pulses %0d required 0/0", err_tx, ovf_cnt);
        else n_pass++;
        n_checks++;
        if (rx_q.size() !== 2) $display("FAIL during_count: got %0d frames required 2", rx_q.size());
        else n_pass++;
        if (rx_q.size() == 2) begin
            n_checks++;
            if (rx_q[0] !== 8'h3C || rx_q[1] !== 8'hC3) $display("FAIL during_bytes: got %h %h required 3c c3", rx_q[0], rx_q[1]);
            else n_pass++;
            n_checks++;
            if (rx_start_q[1] - rx_start_q[0] !== FRAME) $display("FAIL during_gap: got %0d clocks required 100", rx_start_q[1] - rx_start_q[0]);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        logic [7:0] sent [$];
        int budget;
        int bad;
        reset_model();
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 6; k++) begin
                logic [7:0] d;
                d = 8'($urandom);
                sent.push_back(d);
                advance(1'b1, d);
                repeat ($urandom_range(0, 3)) advance(1'b0, 8'h00);
            end
            budget = 1000;
            while (busy !== 1'b0 && budget > 0) begin
                advance(1'b0, 8'h00);
                budget--;
            end
            n_checks++;
            if (budget <= 0) $display("FAIL wrap_drain: busy still %b after 1000 cycles required 0", busy);
            else n_pass++;
        end
        n_checks++;
        if (rx_q.size() !== 18) $display("FAIL wrap_count: got %0d frames required 18", rx_q.size());
        else n_pass++;
        bad = 0;
        for (int i = 0; i < rx_q.size() && i < 18; i++) begin
            if (rx_q[i] !== sent[i] || rx_stop_q[i] !== 1'b1) bad++;
        end
        n_checks++;
        if (bad !== 0 || err_tx !== 0 || err_busy !== 0)
            $display("FAIL wrap_bytes: got %0d wrong bytes, %0d/%0d bad tx/busy cycles required 0", bad, err_tx, err_busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int n;
        reset_model();
        n = cyc + 1;
        advance(1'b1, 8'hFF);
        for (int k = 0; k < 4; k++) advance(1'b1, 8'($urandom));
        while (cyc < n + 45) advance(1'b0, 8'h00);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL mid_prebusy: busy got %b required 1", busy);
        else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({tx, busy, overflow} !== 3'b100) $display("FAIL mid_async: tx/busy/ovf got %b required 100", {tx, busy, overflow});
        else n_pass++;
        repeat (3) @(negedge sys_clk);
        reset_model();
        rst_n = 1'b1;
        repeat (150) advance(1'b0, 8'h00);
        n_checks++;
        if (err_tx !== 0 || err_busy !== 0 || rx_q.size() !== 0)
            $display("FAIL mid_quiet: bad tx %0d busy %0d cycles, %0d frames required 0/0/0", err_tx, err_busy, rx_q.size());
        else n_pass++;
        advance(1'b1, 8'h5A);
        repeat (110) advance(1'b0, 8'h00);
        n_checks++;
        if (rx_q.size() !== 1 || err_tx !== 0) $display("FAIL mid_after: got %0d frames, %0d bad tx cycles required 1/0", rx_q.size(), err_tx);
        else n_pass++;
        if (rx_q.size() == 1) begin
            n_checks++;
            if (rx_q[0] !== 8'h5A) $display("FAIL mid_byte: got %h required 5a", rx_q[0]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int budget;
        int bad;
        reset_model();
        for (int i = 0; i < 3000; i++) advance($urandom_range(0, 29) == 0, 8'($urandom));
        budget = 1200;
        while (busy !== 1'b0 && budget > 0) begin
            advance(1'b0, 8'h00);
            budget--;
        end
        advance(1'b0, 8'h00);
        n_checks++;
        if (budget <= 0) $display("FAIL rand_drain: busy still %b after 1200 cycles required 0", busy);
        else n_pass++;
        n_checks++;
        if (err_tx !== 0 || err_busy !== 0 || err_ovf !== 0)
            $display("FAIL rand_model: tx/busy/ovf bad cycles %0d/%0d/%0d (first %0d/%0d/%0d) required 0", err_tx, err_busy, err_ovf, first_tx, first_busy, first_ovf);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < rx_q.size() && i < m_byte.size(); i++) begin
            if (rx_q[i] !== m_byte[i]) bad++;
        end
        n_checks++;
        if (rx_q.size() !== m_byte.size() || bad !== 0)
            $display("FAIL rand_bytes: got %0d frames (%0d wrong) required %0d frames", rx_q.size(), bad, m_byte.size());
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        rst_n = 1'b0;
        tx_en = 1'b0;
        tx_data = 8'h00;
        test_reset();
        test_single();
        test_burst();
        test_write_during();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
